// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_unit_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

    // Instruction-bus request/response as seen by the fetch stage.
    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic data_ok;
        u32   data;
    } ibus_resp_t;

    // Bundle latched by the decode pipeline register.
    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
        logic exc_misalign;
    } fetch_data_t;

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DISCARD
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_REDIRECT
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pcreg.sv
// rtl/fetch_unit_pcreg.sv - program counter register with redirect / +4 / hold select
//
// Ports:
//   clk, resetn      clock and synchronous active-low reset
//   sel              next-pc source (hold, increment by 4, redirect)
//   redirect_pc      target loaded on PC_REDIRECT
//   pc               current program counter
module fetch_unit_pcreg
    import fetch_unit_pkg::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT
) (
    input  logic    clk,
    input  logic    resetn,
    input  pc_sel_t sel,
    input  u64      redirect_pc,
    output u64      pc
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc <= PC_RESET;
        end else begin
            case (sel)
                PC_INC:      pc <= pc + 64'd4;   // wraps modulo 2^64
                PC_REDIRECT: pc <= redirect_pc;
                default:     pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC ownership, single outstanding bus request, fetch bundle
//
// Optional feature macro: FETCH_MISALIGN_EN (misaligned pc raises exc_misalign instead of fetching).
//
// Ports:
//   clk, resetn               clock and synchronous active-low reset
//   stallF                    decode cannot accept a bundle this cycle
//   redirect, redirect_pc     taken branch/jump from execute
//   ireq_valid, ireq_addr     instruction-bus request
//   iresp_data_ok, iresp_data instruction-bus response (single-cycle pulse)
//   dataF_nxt                 bundle for the decode register input
//   fetch_busy                a bus request is outstanding
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT,
    parameter int XLEN     = 64,
    parameter int ILEN     = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stallF,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [ILEN-1:0] iresp_data,
    output fetch_data_t     dataF_nxt,
    output logic            fetch_busy
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    pc_sel_t      pc_sel;
    u64           pc;
    u64           disc_addr;     // address of the squashed request still on the bus
    u32           buf_instr;
    logic         buf_exc;
    logic         misaligned;
    ibus_req_t    ireq;
    ibus_resp_t   iresp;

    assign iresp = '{data_ok: iresp_data_ok, data: iresp_data};

`ifdef FETCH_MISALIGN_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    fetch_unit_pcreg #(
        .PC_RESET (PC_RESET)
    ) u_pcreg (
        .clk         (clk),
        .resetn      (resetn),
        .sel         (pc_sel),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    // Next-state and next-pc selection. Redirect always wins over stall and
    // over a response arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        pc_sel    = PC_HOLD;
        case (state)
            REQ: begin
                if (redirect) begin
                    pc_sel = PC_REDIRECT;
                    // Nothing left on the bus if the response arrived now or
                    // no request was issued for a misaligned pc.
                    state_nxt = (iresp.data_ok || misaligned) ? REQ : DISCARD;
                end else if (misaligned) begin
                    if (stallF) state_nxt = HOLD;
                end else if (iresp.data_ok) begin
                    if (stallF) state_nxt = HOLD;
                    else        pc_sel    = PC_INC;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_sel    = PC_REDIRECT;
                    state_nxt = REQ;
                end else if (!stallF) begin
                    state_nxt = REQ;
                    if (!buf_exc) pc_sel = PC_INC;
                end
            end
            DISCARD: begin
                if (redirect)      pc_sel    = PC_REDIRECT;
                if (iresp.data_ok) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    // Bus request: in DISCARD the squashed address is held until its response.
    always_comb begin
        ireq.valid = resetn && ((state == REQ && !misaligned) || state == DISCARD);
        ireq.addr  = (state == DISCARD) ? disc_addr : {pc[63:2], 2'b00};
    end

    assign ireq_valid = ireq.valid;
    assign ireq_addr  = ireq.addr;
    assign fetch_busy = ireq.valid;

    always_comb begin
        dataF_nxt = '0;
        if (resetn && !redirect) begin
            if (state == REQ && (misaligned || iresp.data_ok)) begin
                dataF_nxt.valid        = 1'b1;
                dataF_nxt.pc           = pc;
                dataF_nxt.raw_instr    = misaligned ? '0 : iresp.data;
                dataF_nxt.exc_misalign = misaligned;
            end else if (state == HOLD) begin
                dataF_nxt.valid        = 1'b1;
                dataF_nxt.pc           = pc;
                dataF_nxt.raw_instr    = buf_instr;
                dataF_nxt.exc_misalign = buf_exc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= REQ;
            buf_instr <= '0;
            buf_exc   <= 1'b0;
            disc_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == REQ && state_nxt == HOLD) begin
                buf_instr <= misaligned ? '0 : iresp.data;
                buf_exc   <= misaligned;
            end
            if (state == HOLD && redirect) begin
                buf_instr <= '0;
                buf_exc   <= 1'b0;
            end
            if (state == REQ && state_nxt == DISCARD) begin
                disc_addr <= ireq.addr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallF;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    fetch_data_t dataF_nxt;
    logic        fetch_busy;

    int checks   = 0;
    int failures = 0;
    logic [96:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .resetn        (resetn),
        .stallF        (stallF),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dataF_nxt     (dataF_nxt),
        .fetch_busy    (fetch_busy)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [96:0] bundle(input logic [63:0] pc, input logic exc);
        return {pc, (exc ? 32'h0 : instr_of(pc)), exc};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, bus returns the word for the
    // address it sees, accepted bundles are popped from the scoreboard.
    task automatic step(input logic st, input logic rd, input logic [63:0] rpc, input logic dok);
        @(negedge clk);
        stallF        = st;
        redirect      = rd;
        redirect_pc   = rpc;
        iresp_data_ok = dok;
        iresp_data    = dok ? instr_of(ireq_addr) : 32'hdead_beef;
        #1;
        if (dataF_nxt.valid && !st) begin
            if (sb_q.size() == 0)
                chk("sb_unexpected_valid", dataF_nxt.valid, 1'b0);
            else
                chk("sb_bundle", {dataF_nxt.pc, dataF_nxt.raw_instr, dataF_nxt.exc_misalign},
                    sb_q.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        stallF = 1'b0; redirect = 1'b0; redirect_pc = '0;
        iresp_data_ok = 1'b0; iresp_data = '0;
        #1;
        chk("rst_ireq_valid", ireq_valid, 1'b0);
        chk("rst_bundle", dataF_nxt, '0);
        chk("rst_busy", fetch_busy, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Back-to-back fetch, response one cycle after each request.
        step(0, 0, 0, 0);
        chk("s1_addr0", ireq_addr, 64'h8000_0000);
        chk("s1_valid0", ireq_valid, 1'b1);
        chk("s1_busy0", fetch_busy, 1'b1);
        chk("s1_nobundle", dataF_nxt.valid, 1'b0);
        sb_q.push_back(bundle(64'h8000_0000, 0)); step(0, 0, 0, 1);
        step(0, 0, 0, 0); chk("s1_addr4", ireq_addr, 64'h8000_0004);
        sb_q.push_back(bundle(64'h8000_0004, 0)); step(0, 0, 0, 1);
        step(0, 0, 0, 0); chk("s1_addr8", ireq_addr, 64'h8000_0008);
        sb_q.push_back(bundle(64'h8000_0008, 0)); step(0, 0, 0, 1);
        step(0, 0, 0, 0); chk("s1_addrc", ireq_addr, 64'h8000_000c);

        // Stall for 3 cycles coinciding with the response at 8000_0004.
        do_reset();
        step(0, 0, 0, 0);
        sb_q.push_back(bundle(64'h8000_0000, 0)); step(0, 0, 0, 1);
        step(0, 0, 0, 0); chk("s2_addr4", ireq_addr, 64'h8000_0004);
        step(1, 0, 0, 1);
        chk("s2_hold0", dataF_nxt, {1'b1, bundle(64'h8000_0004, 0)});
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0);
            chk("s2_hold_ireq", ireq_valid, 1'b0);
            chk("s2_hold_busy", fetch_busy, 1'b0);
            chk("s2_hold_bundle", dataF_nxt, {1'b1, bundle(64'h8000_0004, 0)});
        end
        sb_q.push_back(bundle(64'h8000_0004, 0)); step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s2_addr8", ireq_addr, 64'h8000_0008);
        chk("s2_valid8", ireq_valid, 1'b1);

        // Redirect while 8000_0008 is outstanding; response two cycles later.
        step(0, 1, 64'h8000_0100, 0);
        chk("s3_redir_nobundle", dataF_nxt.valid, 1'b0);
        step(0, 0, 0, 0);
        chk("s3_disc_addr", ireq_addr, 64'h8000_0008);
        chk("s3_disc_valid", ireq_valid, 1'b1);
        step(0, 0, 0, 1);
        chk("s3_dropped", dataF_nxt.valid, 1'b0);
        step(0, 0, 0, 0);
        chk("s3_addr100", ireq_addr, 64'h8000_0100);

        // Redirect together with the response.
        step(0, 1, 64'h8000_0200, 1);
        chk("s4_nobundle", dataF_nxt.valid, 1'b0);
        step(0, 0, 0, 0);
        chk("s4_addr200", ireq_addr, 64'h8000_0200);
        sb_q.push_back(bundle(64'h8000_0200, 0)); step(0, 0, 0, 1);
        step(0, 0, 0, 0); chk("s4_addr204", ireq_addr, 64'h8000_0204);
        step(0, 1, 64'h8000_0300, 0);
        step(0, 0, 0, 0); chk("s4_disc_addr", ireq_addr, 64'h8000_0204);

        // Reset while in DISCARD.
        do_reset();
        step(0, 0, 0, 0);
        chk("s5_addr", ireq_addr, 64'h8000_0000);
        chk("s5_valid", ireq_valid, 1'b1);
        chk("s5_nobundle", dataF_nxt.valid, 1'b0);

        // Second redirect in DISCARD replaces the target; pc+4 wraps.
        step(0, 1, 64'h8000_0400, 0);
        step(0, 1, 64'hffff_ffff_ffff_fffc, 0);
        chk("s6_disc_addr", ireq_addr, 64'h8000_0000);
        step(0, 0, 0, 1);
        chk("s6_dropped", dataF_nxt.valid, 1'b0);
        step(0, 0, 0, 0);
        chk("s6_addr_top", ireq_addr, 64'hffff_ffff_ffff_fffc);
        sb_q.push_back(bundle(64'hffff_ffff_ffff_fffc, 0)); step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("s6_wrap", ireq_addr, 64'h0);

        // Misaligned redirect target.
        step(0, 1, 64'h8000_0102, 0);
        step(0, 0, 0, 1);
`ifdef FETCH_MISALIGN_EN
        sb_q.push_back(bundle(64'h8000_0102, 1)); step(0, 0, 0, 0);
        chk("s7_noreq", ireq_valid, 1'b0);
        sb_q.push_back(bundle(64'h8000_0102, 1)); step(0, 0, 0, 0);
        chk("s7_noreq2", ireq_valid, 1'b0);
        step(0, 1, 64'h8000_0200, 0);
        chk("s7_redir_nobundle", dataF_nxt.valid, 1'b0);
        step(0, 0, 0, 0);
        chk("s7_addr200", ireq_addr, 64'h8000_0200);
`else
        step(0, 0, 0, 0);
        chk("s7_aligned_addr", ireq_addr, 64'h8000_0100);
        chk("s7_valid", ireq_valid, 1'b1);
        step(0, 1, 64'h8000_0300, 1);
        chk("s7_nobundle", dataF_nxt.valid, 1'b0);
        step(0, 0, 0, 0);
        chk("s7_addr300", ireq_addr, 64'h8000_0300);
`endif

        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Owns the PC, issues one instruction-bus request at a time, and produces the fetch bundle that the decode pipeline register latches.
- Sits between the instruction bus (icache/CBus bridge) and the decode register.
- Handles hazard-unit stalls, execute-stage redirects, and discarding responses for squashed requests.

Parameters:
- PC_RESET, 64'h8000_0000, PC value after reset.
- XLEN, 64, PC width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  synchronous reset, active-low.
- stallF  in  1  hazard unit: decode cannot accept a new bundle this cycle.
- redirect  in  1  execute stage: branch/jump taken, refetch from redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  XLEN  request address.
- iresp_data_ok  in  1  response valid; single-cycle pulse.
- iresp_data  in  ILEN  instruction word, valid with iresp_data_ok.
- dataF_nxt  out  fetch_data_t  {valid, pc[XLEN], raw_instr[ILEN], exc_misalign}; drives the decode register input.
- fetch_busy  out  1  request outstanding; hazard-unit visibility.

Behaviour:
- Reset:
  - Applies on the posedge where resetn=0.
  - state=REQ, pc=PC_RESET, ireq_valid=0 during the reset cycle, dataF_nxt='0, fetch_busy=0.
- States:
  - REQ: ireq_valid=1, ireq_addr=pc, held stable until data_ok.
  - HOLD: instruction buffered, waiting on stall.
  - DISCARD: drop one pending response.
- REQ, data_ok=1:
  - If !stallF: dataF_nxt.valid=1 combinationally with {pc, iresp_data}; pc<=pc+4; stay in REQ.
  - If stallF: buffer the word; go to HOLD.
- HOLD:
  - ireq_valid=0; dataF_nxt presents the buffered bundle with valid=1.
  - On !stallF: pc<=pc+4; go to REQ.
- Redirect (priority over stall; redirect beats a simultaneous data_ok of the squashed instruction):
  - In REQ with data_ok=0: pc<=redirect_pc; go to DISCARD. The bus request cannot be withdrawn.
  - In REQ with data_ok=1: response dropped; pc<=redirect_pc; stay in REQ.
  - In HOLD: buffer cleared; pc<=redirect_pc; go to REQ.
  - In all cases dataF_nxt.valid=0 that cycle.
- DISCARD:
  - ireq_valid=1, ireq_addr=old address; held until the pending response completes.
  - On data_ok: drop the response; go to REQ.
  - A second redirect in DISCARD overwrites the pc target only.
- Bundle validity:
  - dataF_nxt.valid=0 whenever no instruction is presented (REQ waiting, DISCARD).
  - The decode register bubbles on valid=0.
- Arithmetic: pc+4 wraps modulo 2^XLEN with no flag.
- fetch_busy = ireq_valid.
- Reset mid-transaction: the pending response is ignored. Clearing the bus side is the bus bridge's responsibility.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - If pc[1:0]!=0 in REQ, no bus request is issued.
  - dataF_nxt={valid=1, pc, raw_instr=0, exc_misalign=1}, presented immediately, subject to the same stall/HOLD rules.
  - pc advances only by redirect.
- Undefined:
  - pc[1:0] is ignored; ireq_addr={pc[XLEN-1:2],2'b00}.
  - exc_misalign is tied to 0.

Decomposition:
- pipes package:
  - fetch_data_t (struct).
  - fetch_state_t enum {REQ, HOLD, DISCARD}.
  - PC_RESET default constant.
- common package: u64, u32 and the ibus request/response types.
- One natural sub-module: pcreg. Holds the PC register with next-pc select (redirect / +4 / hold) and synchronous active-low reset.

Test Plan:
- Reset release, bus returns data_ok one cycle after each request, no stall:
  - ireq_addr sequence 8000_0000, 8000_0004, 8000_0008.
  - dataF_nxt.valid=1 on each data_ok with the matching pc.
- stallF=1 for 3 cycles coinciding with data_ok at 8000_0004:
  - HOLD entered; ireq_valid=0; bundle (pc=8000_0004) stable for 3 cycles.
  - Next request at 8000_0008 after the stall drops.
- redirect to 8000_0100 while a request for 8000_0008 is outstanding, data_ok two cycles later:
  - DISCARD entered; ireq_addr remains 8000_0008; response dropped (valid=0).
  - Next ireq_addr=8000_0100.
- redirect and data_ok in the same cycle:
  - valid=0; next ireq_addr=redirect_pc; no DISCARD.
- resetn=0 asserted while in DISCARD:
  - Next cycle: state REQ, pc=8000_0000, dataF_nxt.valid=0.
- FETCH_MISALIGN_EN, redirect to 8000_0102:
  - No ireq_valid; bundle with exc_misalign=1 and pc=8000_0102.
  - Without the macro: ireq_addr=8000_0100.
